mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, word-addressed instruction/data memory between two requesters: the fetch stage (read-only) and the execute stage (load/store).
- Sits between the core pipeline and the memory macro.
- Serialises accesses and applies data-first priority with a fetch anti-starvation limit.
- Issues one registered memory cycle per grant and returns read data with a one-cycle done pulse.

Parameters:
ADDR_W, 32, width of word address (pc is a word index)
RD_LATENCY, 2, cycles from mem_en cycle to valid mem_rdata; legal 1..7
STARVE_LIMIT, 4, max consecutive data grants while if_req pending before fetch is forced; legal 1..15

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset, asynchronous, active-low
if_req  in  1  fetch read request, held until if_done
if_addr  in  ADDR_W  fetch word address
if_done  out  1  one-cycle pulse: fetch read complete
if_rdata  out  32  fetch read data, valid while if_done
d_req  in  1  data request, held until d_done
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data word address
d_wdata  in  32  store data
d_wstrb  in  4  store byte enables
d_done  out  1  one-cycle pulse: data access complete
d_rdata  out  32  load data, valid while d_done
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_wstrb  out  4  memory byte enables
mem_addr  out  ADDR_W  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data
busy  out  1  state != IDLE

Behaviour:
- Reset (rstn low, async):
  - state=IDLE; all outputs 0; streak counter 0.
  - In-flight access discarded; no done is generated after reset release.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: arbitrates on each edge.
  - Only one req high: grant it.
  - Both high: grant data unless streak==STARVE_LIMIT, then grant fetch.
  - No req: stay in IDLE.
- On grant (edge leaving IDLE):
  - Latch owner, address, we, wstrb, wdata; go to ISSUE.
  - Requester input changes after grant are ignored.
- ISSUE (exactly 1 cycle):
  - mem_en=1, mem_* = latched values.
  - mem_we=1 only for a data store; mem_wstrb=0 for reads.
  - Store: next state RESP. Load or fetch: next state WAIT.
- WAIT:
  - Down-counter loaded with RD_LATENCY-1 entering WAIT (0 = last cycle); leave WAIT after it reaches 0.
  - mem_rdata is captured at the end of cycle (ISSUE cycle + RD_LATENCY) into the owner's rdata register; go to RESP.
- RESP (1 cycle):
  - Owner's done=1; next state IDLE.
  - The other done stays 0; mem_en=0 in all non-ISSUE states.
- Latency, request-seen edge to done:
  - Read: 2+RD_LATENCY cycles, i.e. done in cycle 2+RD_LATENCY with req first high in cycle 0.
  - Store: done in cycle 2.
- Requester rule: drop or update req by the edge after done.
  - The IDLE cycle following RESP samples req; a still-high req is a new request.
- if_rdata/d_rdata hold their last captured value between accesses; store completion does not modify d_rdata.
- Streak counter:
  - +1 on each data grant while if_req=1 (saturates at STARVE_LIMIT).
  - Cleared on fetch grant or whenever if_req=0 in IDLE.
- Store with d_wstrb=0: still issues a mem cycle (mem_we=1, mem_wstrb=0) and returns d_done.
- Max throughput: one access per 3+RD_LATENCY cycles (reads) or 3 cycles (stores).

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- When defined, adds outputs stat_if_grants[31:0], stat_d_grants[31:0] and stat_wait[31:0]:
  - stat_if_grants: counts fetch grants.
  - stat_d_grants: counts data grants.
  - stat_wait: counts cycles where a req is high and not being serviced for that requester, summed over both requesters.
  - All three wrap at 2^32 and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- RD_LATENCY=2; if_req=1, if_addr=0x10 in cycle 0; memory returns 0xDEADBEEF for addr 0x10:
  - mem_en=1 with mem_addr=0x10 in cycle 1.
  - if_done=1 with if_rdata=0xDEADBEEF in cycle 4.
  - busy low again in cycle 5.
- Store d_req=1, d_we=1, d_addr=0x20, d_wdata=0x12345678, d_wstrb=4'b0011 in cycle 0:
  - mem_en=mem_we=1, mem_wstrb=0011 in cycle 1.
  - d_done in cycle 2; d_rdata unchanged.
- if_req and d_req rise together (load from 0x5, fetch from 0x6):
  - Data granted first (mem_addr=0x5).
  - Fetch issued in the ISSUE cycle following d_done+1 IDLE cycle (mem_addr=0x6).
- STARVE_LIMIT=4; if_req held high, d_req re-asserted back-to-back:
  - Exactly 4 data grants, then the 5th grant goes to fetch.
  - Streak returns to 0, then data resumes.
- Assert rstn low during WAIT of a fetch:
  - All outputs 0 immediately (async).
  - After release, no if_done pulse until a new request.
- With MEM_ARB_STATS_EN: run the STARVE_LIMIT scenario:
  - stat_d_grants=4, stat_if_grants=1 after the first fetch done.
  - stat_wait equals the summed pending-not-serviced cycles computed by the bench.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between a fetch reader and a load/store data port (data-first, fetch anti-starvation).
// Define MEM_ARB_STATS_EN to add the grant/wait statistics outputs.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int RD_LATENCY   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
`ifdef MEM_ARB_STATS_EN
    output logic [31:0]       stat_if_grants,
    output logic [31:0]       stat_d_grants,
    output logic [31:0]       stat_wait,
`endif
    output logic              busy
);

    // state | meaning
    // IDLE  | arbitrate between if_req and d_req on every edge
    // ISSUE | drive the single memory cycle of the granted access
    // WAIT  | count down the read latency, capture mem_rdata on the last cycle
    // RESP  | pulse the owner's done
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] LP_WAIT_LOAD = 3'(RD_LATENCY - 1);
    localparam logic [3:0] LP_LIMIT     = 4'(STARVE_LIMIT);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner_d;
    logic                r_we;
    logic [3:0]          r_wstrb;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [2:0]          r_wait_cnt;
    logic [3:0]          r_streak;
    logic [31:0]         r_if_rdata;
    logic [31:0]         r_d_rdata;
    logic                w_grant_d;

    // Data wins unless fetch has already waited through STARVE_LIMIT data grants.
    assign w_grant_d = d_req && !(if_req && (r_streak == LP_LIMIT));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_wstrb   = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if_done     = 1'b0;
        d_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (if_req || d_req) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_en      = 1'b1;
                mem_we      = r_we;
                mem_wstrb   = r_wstrb;
                mem_addr    = r_addr;
                mem_wdata   = r_wdata;
                w_state_nxt = r_we ? RESP : WAIT;
            end
            WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if_done     = !r_owner_d;
                d_done      = r_owner_d;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_owner_d  <= 1'b0;
            r_we       <= 1'b0;
            r_wstrb    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wait_cnt <= '0;
            r_streak   <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (!if_req) begin
                    r_streak <= '0;
                end else if (w_grant_d) begin
                    if (r_streak != LP_LIMIT) begin
                        r_streak <= r_streak + 4'd1;
                    end
                end else begin
                    r_streak <= '0;
                end

                if (w_grant_d) begin
                    r_owner_d <= 1'b1;
                    r_we      <= d_we;
                    r_addr    <= d_addr;
                    r_wdata   <= d_wdata;
                    r_wstrb   <= d_we ? d_wstrb : 4'b0000;
                end else if (if_req) begin
                    r_owner_d <= 1'b0;
                    r_we      <= 1'b0;
                    r_addr    <= if_addr;
                    r_wdata   <= '0;
                    r_wstrb   <= '0;
                end
            end

            if (r_state == ISSUE) begin
                r_wait_cnt <= LP_WAIT_LOAD;
            end else if ((r_state == WAIT) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
            end

            if ((r_state == WAIT) && (r_wait_cnt == '0)) begin
                if (r_owner_d) begin
                    r_d_rdata <= mem_rdata;
                end else begin
                    r_if_rdata <= mem_rdata;
                end
            end
        end
    end

    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;
    assign busy     = (r_state != IDLE);

`ifdef MEM_ARB_STATS_EN
    logic        w_grant;
    logic        w_if_wait;
    logic        w_d_wait;
    logic [31:0] r_stat_if_grants;
    logic [31:0] r_stat_d_grants;
    logic [31:0] r_stat_wait;

    // A requester is serviced from ISSUE through RESP of its own access.
    assign w_grant   = (r_state == IDLE) && (if_req || d_req);
    assign w_if_wait = if_req && !((r_state != IDLE) && !r_owner_d);
    assign w_d_wait  = d_req && !((r_state != IDLE) && r_owner_d);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stat_if_grants <= '0;
            r_stat_d_grants  <= '0;
            r_stat_wait      <= '0;
        end else begin
            if (w_grant && w_grant_d) begin
                r_stat_d_grants <= r_stat_d_grants + 32'd1;
            end
            if (w_grant && !w_grant_d) begin
                r_stat_if_grants <= r_stat_if_grants + 32'd1;
            end
            r_stat_wait <= r_stat_wait + 32'(w_if_wait) + 32'(w_d_wait);
        end
    end

    assign stat_if_grants = r_stat_if_grants;
    assign stat_d_grants  = r_stat_d_grants;
    assign stat_wait      = r_stat_wait;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level arbitration model plus a latency-accurate memory model.
// Stats outputs are checked when MEM_ARB_STATS_EN is defined.
module tb_mem_port_arbiter;

    localparam int ADDR_W       = 32;
    localparam int RD_LATENCY   = 2;
    localparam int STARVE_LIMIT = 4;

    localparam int M_DIRECTED = 0;
    localparam int M_MIXED    = 1;
    localparam int M_STARVE   = 2;
    localparam int M_FETCH    = 3;
    localparam int M_SPARSE   = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_done;
    logic [31:0]       d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              busy;
`ifdef MEM_ARB_STATS_EN
    logic [31:0]       stat_if_grants;
    logic [31:0]       stat_d_grants;
    logic [31:0]       stat_wait;
`endif

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .RD_LATENCY  (RD_LATENCY),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wstrb  (d_wstrb),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_wstrb(mem_wstrb),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
`ifdef MEM_ARB_STATS_EN
        .stat_if_grants(stat_if_grants),
        .stat_d_grants (stat_d_grants),
        .stat_wait     (stat_wait),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = -1;

    // reference state: one access in flight at most, described by grant and done cycle
    bit          acc_valid;
    bit          acc_d;
    bit          acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wstrb;
    logic [31:0] acc_rdata;
    int          acc_g;
    int          acc_done;
    int          streak;
    int          n_forced;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
    logic [31:0] ref_mem [64];
    logic [31:0] mem_arr [64];
    int          rd_ret_cyc;
    logic [31:0] rd_ret_data;
    bit          f_pend;
    int          f_done;
    bit          d_pend;
    int          d_done_cyc;
    logic [31:0] m_if_gr, m_d_gr, m_wait;
    logic [31:0] e_if_gr, e_d_gr, e_wait;
    bit          e_issue, e_busy, e_ifdone, e_ddone;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    task automatic model_reset();
        acc_valid    = 1'b0;
        acc_g        = -100;
        acc_done     = -100;
        streak       = 0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        f_pend       = 1'b0;
        f_done       = -1;
        d_pend       = 1'b0;
        d_done_cyc   = -1;
        rd_ret_cyc   = -100;
        m_if_gr      = '0;
        m_d_gr       = '0;
        m_wait       = '0;
    endtask

    task automatic raise_f(input logic [31:0] a);
        if_req = 1'b1; if_addr = a; f_pend = 1'b1; f_done = -1;
    endtask

    task automatic raise_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_wstrb = s; d_pend = 1'b1; d_done_cyc = -1;
    endtask

    task automatic gen_stim(input int mode);
        int fr, fn, dr, dn;
        fr = 0; fn = 0; dr = 0; dn = 0;
        case (mode)
            M_MIXED:  begin fr = 30;  fn = 30; dr = 30;  dn = 40; end
            M_STARVE: begin fr = 100; fn = 60; dr = 100; dn = 95; end
            M_FETCH:  begin fr = 60;  fn = 50; dr = 0;   dn = 0;  end
            M_SPARSE: begin fr = 8;   fn = 0;  dr = 8;   dn = 0;  end
            default:  begin fr = 0;   fn = 0;  dr = 0;   dn = 0;  end
        endcase
        if (f_pend && f_done >= 0 && cyc == f_done + 1) begin
            if (int'($urandom_range(0, 99)) < fn) raise_f($urandom_range(0, 63));
            else begin if_req = 1'b0; f_pend = 1'b0; if_addr = $urandom; end
        end else if (!f_pend) begin
            if (int'($urandom_range(0, 99)) < fr) raise_f($urandom_range(0, 63));
            else if_addr = $urandom;
        end else if (f_done >= 0) begin
            if_addr = $urandom;
        end
        if (d_pend && d_done_cyc >= 0 && cyc == d_done_cyc + 1) begin
            if (int'($urandom_range(0, 99)) < dn)
                raise_d(1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom, 4'($urandom_range(0, 15)));
            else begin d_req = 1'b0; d_pend = 1'b0; d_addr = $urandom; end
        end else if (!d_pend) begin
            if (int'($urandom_range(0, 99)) < dr)
                raise_d(1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom, 4'($urandom_range(0, 15)));
            else d_addr = $urandom;
        end else if (d_done_cyc >= 0) begin
            d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic model_step();
        bit gd;
        e_if_gr  = m_if_gr;
        e_d_gr   = m_d_gr;
        e_wait   = m_wait;
        e_issue  = acc_valid && (cyc == acc_g + 1);
        e_busy   = acc_valid && (cyc > acc_g) && (cyc <= acc_done);
        e_ifdone = e_busy && (cyc == acc_done) && !acc_d;
        e_ddone  = e_busy && (cyc == acc_done) && acc_d;
        if (e_ifdone) exp_if_rdata = acc_rdata;
        if (e_ddone && !acc_we) exp_d_rdata = acc_rdata;
        m_wait = m_wait + 32'(if_req && !(e_busy && !acc_d)) + 32'(d_req && !(e_busy && acc_d));
        if (!e_busy) begin
            if (!if_req) streak = 0;
            if (if_req || d_req) begin
                gd = d_req && !(if_req && streak == STARVE_LIMIT);
                acc_valid = 1'b1;
                acc_g     = cyc;
                acc_d     = gd;
                if (gd) begin
                    acc_we    = d_we;
                    acc_addr  = d_addr;
                    acc_wdata = d_wdata;
                    acc_wstrb = d_we ? d_wstrb : 4'b0000;
                    m_d_gr    = m_d_gr + 32'd1;
                    streak    = if_req ? ((streak < STARVE_LIMIT) ? streak + 1 : streak) : 0;
                end else begin
                    if (d_req) n_forced++;
                    acc_we    = 1'b0;
                    acc_addr  = if_addr;
                    acc_wdata = '0;
                    acc_wstrb = '0;
                    m_if_gr   = m_if_gr + 32'd1;
                    streak    = 0;
                end
                acc_done = cyc + 2 + (acc_we ? 0 : RD_LATENCY);
                if (acc_we) ref_mem[acc_addr[5:0]] = merge(ref_mem[acc_addr[5:0]], acc_wdata, acc_wstrb);
                else acc_rdata = ref_mem[acc_addr[5:0]];
                if (gd) d_done_cyc = acc_done;
                else f_done = acc_done;
            end
        end
    endtask

    task automatic check_cycle();
        chk("mem_en", mem_en, e_issue);
        chk("busy", busy, e_busy);
        chk("if_done", if_done, e_ifdone);
        chk("d_done", d_done, e_ddone);
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        if (e_issue) begin
            chk("mem_addr", mem_addr, acc_addr);
            chk("mem_we", mem_we, acc_we);
            chk("mem_wstrb", mem_wstrb, acc_wstrb);
            if (acc_we) chk("mem_wdata", mem_wdata, acc_wdata);
        end else begin
            chk("mem_we_idle", mem_we, 1'b0);
        end
`ifdef MEM_ARB_STATS_EN
        chk("stat_if_grants", stat_if_grants, e_if_gr);
        chk("stat_d_grants", stat_d_grants, e_d_gr);
        chk("stat_wait", stat_wait, e_wait);
`endif
    endtask

    task automatic mem_update();
        if (mem_en) begin
            if (mem_we) mem_arr[mem_addr[5:0]] = merge(mem_arr[mem_addr[5:0]], mem_wdata, mem_wstrb);
            else begin
                rd_ret_cyc  = cyc + RD_LATENCY;
                rd_ret_data = mem_arr[mem_addr[5:0]];
            end
        end
    endtask

    task automatic step(input int mode);
        @(posedge clk);
        #1;
        cyc++;
        mem_rdata = (cyc == rd_ret_cyc) ? rd_ret_data : $urandom;
        gen_stim(mode);
    endtask

    task automatic finish_step();
        model_step();
        @(negedge clk);
        check_cycle();
        mem_update();
    endtask

    task automatic run_cycles(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            step(mode);
            finish_step();
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_mem_en"}, mem_en, 1'b0);
        chk({pfx, "_mem_we"}, mem_we, 1'b0);
        chk({pfx, "_mem_wstrb"}, mem_wstrb, 4'h0);
        chk({pfx, "_mem_addr"}, mem_addr, 32'h0);
        chk({pfx, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({pfx, "_if_done"}, if_done, 1'b0);
        chk({pfx, "_d_done"}, d_done, 1'b0);
        chk({pfx, "_if_rdata"}, if_rdata, 32'h0);
        chk({pfx, "_d_rdata"}, d_rdata, 32'h0);
        chk({pfx, "_busy"}, busy, 1'b0);
`ifdef MEM_ARB_STATS_EN
        chk({pfx, "_stat_if_grants"}, stat_if_grants, 32'h0);
        chk({pfx, "_stat_d_grants"}, stat_d_grants, 32'h0);
        chk({pfx, "_stat_wait"}, stat_wait, 32'h0);
`endif
    endtask

    task automatic reset_in_fetch_wait();
        bit hit;
        hit = 1'b0;
        for (int b = 0; b < 300 && !hit; b++) begin
            step(M_FETCH);
            finish_step();
            if (acc_valid && !acc_d && cyc >= acc_g + 2 && cyc < acc_done) hit = 1'b1;
        end
        chk("rst_fetch_wait_reached", hit, 1'b1);
        #1;
        rstn   = 1'b0;
        if_req = 1'b0;
        d_req  = 1'b0;
        #1;
        chk_all_zero("rst_async");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        rstn      = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_wstrb   = '0;
        mem_rdata = '0;
        n_forced  = 0;
        model_reset();
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            mem_arr[i] = v;
        end
        ref_mem[16] = 32'hDEADBEEF;
        mem_arr[16] = 32'hDEADBEEF;

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 24; i++) begin
            step(M_DIRECTED);
            if (i == 0) raise_f(32'h10);
            if (i == 6) raise_d(1'b1, 32'h20, 32'h12345678, 4'b0011);
            if (i == 10) begin
                raise_d(1'b0, 32'h5, 32'h0, 4'h0);
                raise_f(32'h6);
            end
            finish_step();
            if (i == 1) chk("tp_issue_addr", mem_addr, 32'h10);
            if (i == 4) chk("tp_if_rdata", if_rdata, 32'hDEADBEEF);
            if (i == 5) chk("tp_busy_low", busy, 1'b0);
            if (i == 11) chk("tp_data_first", mem_addr, 32'h5);
            if (i == 16) chk("tp_fetch_second", mem_addr, 32'h6);
        end

        run_cycles(300, M_MIXED);
        run_cycles(300, M_STARVE);
        reset_in_fetch_wait();
        run_cycles(100, M_SPARSE);
        run_cycles(300, M_MIXED);
        run_cycles(300, M_STARVE);
        run_cycles(200, M_FETCH);

        $display("info: %0d fetch grants forced by the streak limit", n_forced);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
